instruction_decode_stage: RTL

Parametrised, registered instruction-decode pipeline stage for the CPU datapath. It sits between instruction fetch and the register file/ALU. It accepts one instruction word per cycle with its PC over a valid/ready handshake and splits it into opcode, register addresses, immediate and sign-extended offset. A two-entry skid buffer lets back-pressure from execute stall the stage without losing instructions, and a synchronous flush drops in-flight instructions on a taken branch or jump.

---
 rtl/instruction_decode_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instruction_decode_stage.sv
// Purpose : registered decode stage; splits an instruction word into opcode,
//           register addresses, immediate and sign-extended offset.
// Latency : 1 cycle from input transfer to OUT_VALID; 1 instruction/cycle.
// Backpres: two-entry (main + skid) buffer; IN_READY = !skid_valid (flop).
//
// Ports:
//   CLK, RESET (async, active-high), FLUSH (sync, drops everything held/incoming)
//   IN_VALID/IN_READY/IN_INSTR/IN_PC       : fetch-side handshake
//   OUT_VALID/OUT_READY                    : execute-side handshake
//   OPCODE, WRITEREG, READREG1, READREG2,
//   IMMEDIATE, OFFSET, OUT_PC              : decoded fields, straight from flops
// REG_ADDR_W must not exceed BYTE_W; OFFSET_W must be at least BYTE_W.
module instruction_decode_stage #(
  parameter int BYTE_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32,
  parameter int OFFSET_W   = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [4*BYTE_W-1:0]   IN_INSTR,
  input  logic [PC_W-1:0]       IN_PC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [BYTE_W-1:0]     OPCODE,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [BYTE_W-1:0]     IMMEDIATE,
  output logic [OFFSET_W-1:0]   OFFSET,
  output logic [PC_W-1:0]       OUT_PC
);

  localparam int INSTR_W = 4 * BYTE_W;

  typedef struct packed {
    logic [BYTE_W-1:0]     opcode;
    logic [REG_ADDR_W-1:0] writereg;
    logic [REG_ADDR_W-1:0] readreg1;
    logic [REG_ADDR_W-1:0] readreg2;
    logic [BYTE_W-1:0]     immediate;
    logic [OFFSET_W-1:0]   offset;
    logic [PC_W-1:0]       pc;
  } dec_t;

  // Field split. The offset byte doubles as the write-register byte; the
  // signed size cast performs the sign extension up to OFFSET_W.
  function automatic dec_t decode(input logic [INSTR_W-1:0] instr,
                                  input logic [PC_W-1:0]    pc);
    dec_t d;
    d.opcode    = instr[4*BYTE_W-1:3*BYTE_W];
    d.writereg  = instr[2*BYTE_W +: REG_ADDR_W];
    d.readreg1  = instr[BYTE_W   +: REG_ADDR_W];
    d.readreg2  = instr[0        +: REG_ADDR_W];
    d.immediate = instr[BYTE_W-1:0];
    d.offset    = OFFSET_W'($signed(instr[3*BYTE_W-1:2*BYTE_W]));
    d.pc        = pc;
    return d;
  endfunction

  dec_t in_dat;
  dec_t main_dat;
  dec_t skid_dat;
  logic main_vld;
  logic skid_vld;
  logic in_xfer;
  logic out_xfer;

  // Upper bits of the read-register-1 byte never reach an output.
  logic unused_rr1_bits;
  assign unused_rr1_bits = ^IN_INSTR[2*BYTE_W-1:BYTE_W];

  assign in_dat   = decode(IN_INSTR, IN_PC);
  assign IN_READY = ~skid_vld;
  assign in_xfer  = IN_VALID & ~skid_vld;
  assign out_xfer = main_vld & OUT_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (FLUSH) begin
      // A consumed instruction still counts as delivered; everything else,
      // including this cycle's input, is dropped.
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || out_xfer) begin
      if (skid_vld) begin
        // Skid is older than any input; IN_READY is low so nothing arrives.
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        // Only load on a real transfer so stale fields stay put.
        if (in_xfer) begin
          main_dat <= in_dat;
        end
        main_vld <= in_xfer;
        skid_vld <= 1'b0;
      end
    end else if (in_xfer) begin
      // Main is stalled; park the new instruction in skid.
      skid_dat <= in_dat;
      skid_vld <= 1'b1;
    end
  end

  assign OUT_VALID = main_vld;
  assign OPCODE    = main_dat.opcode;
  assign WRITEREG  = main_dat.writereg;
  assign READREG1  = main_dat.readreg1;
  assign READREG2  = main_dat.readreg2;
  assign IMMEDIATE = main_dat.immediate;
  assign OFFSET    = main_dat.offset;
  assign OUT_PC    = main_dat.pc;

endmodule
